// File: rtl/cavlc_pkg.sv
// Shared types for the CAVLC residual-block controllers: FSM states, phases and per-mode coefficient limits.
package cavlc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BS,
        S_COEFF,
        S_LEVEL,
        S_TZ,
        S_RUN,
        S_BLK_END,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_CT,
        PH_LVL,
        PH_TZ,
        PH_RB
    } phase_t;

    localparam int MAX_COEFF_LUMA      = 16;
    localparam int MAX_COEFF_AC        = 15;
    localparam int MAX_COEFF_CHROMA_DC = 4;

    function automatic logic isPhase(state_t s);
        return (s == S_COEFF) || (s == S_LEVEL) || (s == S_TZ) || (s == S_RUN);
    endfunction

    function automatic phase_t phaseOf(state_t s);
        case (s)
            S_LEVEL: return PH_LVL;
            S_TZ:    return PH_TZ;
            S_RUN:   return PH_RB;
            default: return PH_CT;
        endcase
    endfunction

endpackage

// File: rtl/cavlc_shift_mux.sv
// Routes the active sub-decoder's shift request onto the single barrel-shifter port.
// Purely combinational; with no phase selected the shifter sees no request.
module cavlc_shift_mux
    import cavlc_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  logic               PhaseVld,
    input  phase_t             Phase,
    input  logic               CtShiftEn,
    input  logic               LvlShiftEn,
    input  logic               TzShiftEn,
    input  logic               RbShiftEn,
    input  logic [SHIFT_W-1:0] CtNumShift,
    input  logic [SHIFT_W-1:0] LvlNumShift,
    input  logic [SHIFT_W-1:0] TzNumShift,
    input  logic [SHIFT_W-1:0] RbNumShift,
    output logic               ShiftEn,
    output logic [SHIFT_W-1:0] NumShift
);

    always_comb begin
        ShiftEn  = 1'b0;
        NumShift = '0;
        if (PhaseVld) begin
            case (Phase)
                PH_CT:   begin ShiftEn = CtShiftEn;  NumShift = CtNumShift;  end
                PH_LVL:  begin ShiftEn = LvlShiftEn; NumShift = LvlNumShift; end
                PH_TZ:   begin ShiftEn = TzShiftEn;  NumShift = TzNumShift;  end
                default: begin ShiftEn = RbShiftEn;  NumShift = RbNumShift;  end
            endcase
        end
    end

endmodule

// File: rtl/cavlc_block_ctrl.sv
// Sequences coeff_token/level/total_zeros/run_before for NUM_BLOCKS residual blocks per Start,
// skipping phases by TotalCoeff/TotalZeros and trapping malformed streams or stalled decoders in ERR.
module cavlc_block_ctrl
    import cavlc_pkg::*;
#(
    parameter int SHIFT_W    = 5,
    parameter int MAX_COEFF  = MAX_COEFF_LUMA,
    parameter int NUM_BLOCKS = 16,
    parameter int TIMEOUT    = 255,
    localparam int BI_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Start,
    input  logic               Abort,
    input  logic               BarrelShifterReady,
    input  logic               CtDone,
    input  logic               LvlDone,
    input  logic               TzDone,
    input  logic               RbDone,
    input  logic               CtShiftEn,
    input  logic               LvlShiftEn,
    input  logic               TzShiftEn,
    input  logic               RbShiftEn,
    input  logic [SHIFT_W-1:0] CtNumShift,
    input  logic [SHIFT_W-1:0] LvlNumShift,
    input  logic [SHIFT_W-1:0] TzNumShift,
    input  logic [SHIFT_W-1:0] RbNumShift,
    input  logic [4:0]         TotalCoeff,
    input  logic [4:0]         TotalZeros,
    output logic               ShiftEn,
    output logic [SHIFT_W-1:0] NumShift,
    output logic               CtEnable,
    output logic               LvlEnable,
    output logic               TzEnable,
    output logic               RbEnable,
    output logic [BI_W-1:0]    BlockIdx,
    output logic               BlockDone,
    output logic               RunDone,
    output logic               Busy,
    output logic               Error
);

    localparam int              TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [5:0]      MAXC     = 6'(MAX_COEFF);
    localparam logic [BI_W-1:0] LAST_BLK = BI_W'(NUM_BLOCKS - 1);

    state_t          state, nextState;
    phase_t          phase;
    logic            inPhase, curDone, timedOut, lastBlk;
    logic [4:0]      tcReg;
    logic [5:0]      tzSum;
    logic [TO_W-1:0] toCnt;
    logic [BI_W-1:0] blockIdx;

    assign inPhase = isPhase(state);
    assign phase   = phaseOf(state);
    assign lastBlk = (blockIdx == LAST_BLK);
    assign tzSum   = {1'b0, tcReg} + {1'b0, TotalZeros};

    always_comb begin
        curDone = 1'b0;
        case (phase)
            PH_CT:   curDone = CtDone;
            PH_LVL:  curDone = LvlDone;
            PH_TZ:   curDone = TzDone;
            default: curDone = RbDone;
        endcase
    end

    // A Done in the same cycle the budget runs out still counts as on time.
    assign timedOut = TO_EN && inPhase && !curDone && (toCnt == TO_LAST);

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:    if (Start) nextState = S_WAIT_BS;
            S_WAIT_BS: if (BarrelShifterReady) nextState = S_COEFF;
            S_COEFF: if (CtDone) begin
                if ({1'b0, TotalCoeff} > MAXC)  nextState = S_ERR;
                else if (TotalCoeff == 5'd0)    nextState = S_BLK_END;
                else                            nextState = S_LEVEL;
            end
            S_LEVEL: if (LvlDone) nextState = ({1'b0, tcReg} == MAXC) ? S_BLK_END : S_TZ;
            S_TZ: if (TzDone) begin
                if (tzSum > MAXC)               nextState = S_ERR;
                else if (TotalZeros == 5'd0)    nextState = S_BLK_END;
                else                            nextState = S_RUN;
            end
            S_RUN:     if (RbDone) nextState = S_BLK_END;
            S_BLK_END: nextState = lastBlk ? S_IDLE : S_WAIT_BS;
            S_ERR:     nextState = S_ERR;
            default:   nextState = S_IDLE;
        endcase
        if (timedOut) nextState = S_ERR;
        if (Abort)    nextState = S_IDLE;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= S_IDLE;
            tcReg     <= '0;
            toCnt     <= '0;
            blockIdx  <= '0;
            CtEnable  <= 1'b0;
            LvlEnable <= 1'b0;
            TzEnable  <= 1'b0;
            RbEnable  <= 1'b0;
        end else begin
            state     <= nextState;
            CtEnable  <= (nextState == S_COEFF) && (state != S_COEFF);
            LvlEnable <= (nextState == S_LEVEL) && (state != S_LEVEL);
            TzEnable  <= (nextState == S_TZ)    && (state != S_TZ);
            RbEnable  <= (nextState == S_RUN)   && (state != S_RUN);
            if (state == S_COEFF && CtDone && !Abort)
                tcReg <= TotalCoeff;
            if (nextState != state)
                toCnt <= '0;
            else if (inPhase)
                toCnt <= toCnt + 1'b1;
            if (Abort || (state == S_IDLE && Start))
                blockIdx <= '0;
            else if (state == S_BLK_END)
                blockIdx <= lastBlk ? '0 : blockIdx + 1'b1;
        end
    end

    assign BlockIdx  = blockIdx;
    assign BlockDone = (state == S_BLK_END);
    assign RunDone   = (state == S_BLK_END) && lastBlk;
    assign Busy      = (state != S_IDLE) && (state != S_ERR);
    assign Error     = (state == S_ERR);

    cavlc_shift_mux #(.SHIFT_W(SHIFT_W)) uShiftMux (
        .PhaseVld    (inPhase),
        .Phase       (phase),
        .CtShiftEn   (CtShiftEn),
        .LvlShiftEn  (LvlShiftEn),
        .TzShiftEn   (TzShiftEn),
        .RbShiftEn   (RbShiftEn),
        .CtNumShift  (CtNumShift),
        .LvlNumShift (LvlNumShift),
        .TzNumShift  (TzNumShift),
        .RbNumShift  (RbNumShift),
        .ShiftEn     (ShiftEn),
        .NumShift    (NumShift)
    );

endmodule

// File: tb/tb_cavlc_block_ctrl.sv
// Scoreboard bench: a block-level reference model queues expected controller events, a monitor pops them.
module tb_cavlc_block_ctrl;

    localparam int SW = 5, MAXC = 16, NB = 4, TO = 8;
    localparam int EV_CT = 1, EV_LVL = 2, EV_TZ = 3, EV_RB = 4, EV_BLK = 5, EV_ERR = 6;

    logic Clk = 1'b0, nReset = 1'b0;
    logic Start = 0, Abort = 0, BarrelShifterReady = 1;
    logic CtDone = 0, LvlDone = 0, TzDone = 0, RbDone = 0;
    logic CtShiftEn = 0, LvlShiftEn = 0, TzShiftEn = 0, RbShiftEn = 0;
    logic [SW-1:0] CtNumShift = '0, LvlNumShift = '0, TzNumShift = '0, RbNumShift = '0;
    logic [4:0] TotalCoeff = '0, TotalZeros = '0;
    logic ShiftEn, CtEnable, LvlEnable, TzEnable, RbEnable, BlockDone, RunDone, Busy, Error;
    logic [SW-1:0] NumShift;
    logic [1:0] BlockIdx;

    cavlc_block_ctrl #(.SHIFT_W(SW), .MAX_COEFF(MAXC), .NUM_BLOCKS(NB), .TIMEOUT(TO)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Abort(Abort),
        .BarrelShifterReady(BarrelShifterReady),
        .CtDone(CtDone), .LvlDone(LvlDone), .TzDone(TzDone), .RbDone(RbDone),
        .CtShiftEn(CtShiftEn), .LvlShiftEn(LvlShiftEn), .TzShiftEn(TzShiftEn), .RbShiftEn(RbShiftEn),
        .CtNumShift(CtNumShift), .LvlNumShift(LvlNumShift), .TzNumShift(TzNumShift), .RbNumShift(RbNumShift),
        .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
        .ShiftEn(ShiftEn), .NumShift(NumShift),
        .CtEnable(CtEnable), .LvlEnable(LvlEnable), .TzEnable(TzEnable), .RbEnable(RbEnable),
        .BlockIdx(BlockIdx), .BlockDone(BlockDone), .RunDone(RunDone), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    int checks = 0, failures = 0;
    int expQ[$];
    int activePh = 0;
    bit clrPh = 0, prevErr = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int blkEv(int idx, bit last);
        return EV_BLK * 64 + idx * 2 + int'(last);
    endfunction

    // Reference: which phases a block visits follows directly from TotalCoeff/TotalZeros.
    function automatic void model_block(int tc, int tz, int idx, output bit err);
        err = 0;
        expQ.push_back(EV_CT);
        if (tc > MAXC) begin expQ.push_back(EV_ERR); err = 1; return; end
        if (tc > 0) begin
            expQ.push_back(EV_LVL);
            if (tc < MAXC) begin
                expQ.push_back(EV_TZ);
                if (tc + tz > MAXC) begin expQ.push_back(EV_ERR); err = 1; return; end
                if (tz > 0) expQ.push_back(EV_RB);
            end
        end
        expQ.push_back(blkEv(idx, idx == NB - 1));
    endfunction

    task automatic pop(int act);
        if (expQ.size() == 0) chk("unexpected_event", act, 0);
        else chk("event", act, expQ.pop_front());
    endtask

    always @(negedge Clk) begin
        #1;
        if (nReset) begin
            if (CtEnable)  pop(EV_CT);
            if (LvlEnable) pop(EV_LVL);
            if (TzEnable)  pop(EV_TZ);
            if (RbEnable)  pop(EV_RB);
            if (BlockDone) pop(blkEv(int'(BlockIdx), RunDone));
            if (RunDone)   chk("rundone_with_blockdone", BlockDone, 1);
            if (Error && !prevErr) pop(EV_ERR);
            prevErr = Error;
        end
    end

    task automatic check_shift();
        logic eEn;
        logic [SW-1:0] eN;
        case (activePh)
            1:       begin eEn = CtShiftEn;  eN = CtNumShift;  end
            2:       begin eEn = LvlShiftEn; eN = LvlNumShift; end
            3:       begin eEn = TzShiftEn;  eN = TzNumShift;  end
            4:       begin eEn = RbShiftEn;  eN = RbNumShift;  end
            default: begin eEn = 1'b0;       eN = '0;          end
        endcase
        chk("shift_en", ShiftEn, eEn);
        chk("num_shift", NumShift, eN);
    endtask

    task automatic tick();
        @(negedge Clk);
        {CtDone, LvlDone, TzDone, RbDone, Start, Abort} = '0;
        if (clrPh || Error) activePh = 0;
        clrPh = 0;
        if (CtEnable) activePh = 1;
        else if (LvlEnable) activePh = 2;
        else if (TzEnable) activePh = 3;
        else if (RbEnable) activePh = 4;
        {CtShiftEn, LvlShiftEn, TzShiftEn, RbShiftEn} = 4'($urandom);
        CtNumShift = SW'($urandom); LvlNumShift = SW'($urandom);
        TzNumShift = SW'($urandom); RbNumShift = SW'($urandom);
        TotalCoeff = 5'($urandom); TotalZeros = 5'($urandom);
        #1 check_shift();
    endtask

    task automatic wait_any(output int w, output int n);
        w = 0; n = 0;
        while (w == 0 && n < 40) begin
            tick(); n++;
            if (CtEnable) w = 1;
            else if (LvlEnable) w = 2;
            else if (TzEnable) w = 3;
            else if (RbEnable) w = 4;
            else if (BlockDone) w = 5;
            else if (Error) w = 6;
        end
        if (w == 0) begin
            checks++; failures++;
            $display("FAIL wait_any: no controller event within %0d cycles", n);
        end
    endtask

    task automatic pulse(int w, int d, int tc, int tz);
        for (int k = 0; k < d; k++) begin
            tick();
            if ($urandom_range(0, 3) == 0) Start = 1;
        end
        case (w)
            1: begin CtDone = 1; TotalCoeff = 5'(tc); end
            2: LvlDone = 1;
            3: begin TzDone = 1; TotalZeros = 5'(tz); end
            4: RbDone = 1;
            default: ;
        endcase
        clrPh = 1;
        #1 check_shift();
    endtask

    task automatic serve_block(int tc, int tz, int dly, output int res, output int firstN);
        int w, n;
        res = 0; firstN = 0;
        for (int s = 0; s < 6; s++) begin
            wait_any(w, n);
            if (s == 0) firstN = n;
            if (w == 0 || w >= 5) begin res = w; return; end
            pulse(w, (dly < 0) ? $urandom_range(0, 4) : dly, tc, tz);
        end
    endtask

    task automatic recover(int res);
        if (res == 6) begin
            chk("err_flag", Error, 1);
            chk("err_busy", Busy, 0);
            Start = 1;
            tick(); tick();
            chk("err_sticky_after_start", Error, 1);
        end
        Abort = 1;
        tick();
        chk("abort_clears_err", Error, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_idx", BlockIdx, 0);
    endtask

    int m2tc[4] = '{0, 16, 3, 15};
    int m2tz[4] = '{7, 3, 0, 1};

    // mode 0 random, 1 fixed 3/2 with shifter stall before block 2, 2 skip patterns, 3 bad TotalZeros
    task automatic do_run(int mode);
        int tc, tz, res, n, r;
        bit err;
        tick(); Start = 1;
        for (int b = 0; b < NB; b++) begin
            case (mode)
                1: begin tc = 3; tz = 2; end
                2: begin tc = m2tc[b]; tz = m2tz[b]; end
                3: begin tc = 5; tz = 12; end
                default: begin
                    r = $urandom_range(0, 9);
                    if (r == 0) tc = 0;
                    else if (r == 1) tc = MAXC;
                    else if (r == 2) tc = $urandom_range(MAXC + 1, 31);
                    else tc = $urandom_range(1, MAXC - 1);
                    if (tc <= MAXC && $urandom_range(0, 5) == 0) tz = $urandom_range(MAXC + 1 - tc, 31);
                    else tz = $urandom_range(0, (tc <= MAXC) ? MAXC - tc : 0);
                end
            endcase
            if (mode == 1 && b == 2) begin
                BarrelShifterReady = 0;
                repeat (3) begin tick(); chk("busy_in_wait_bs", Busy, 1); end
                BarrelShifterReady = 1;
            end
            model_block(tc, tz, b, err);
            serve_block(tc, tz, (mode == 1) ? 2 : -1, res, n);
            chk("coeff_latency", n, (mode == 1 && b == 2) ? 1 : 2);
            chk("block_result", res, err ? 6 : 5);
            if (res != 5) begin
                recover(res);
                chk("queue_drained", expQ.size(), 0);
                expQ.delete();
                return;
            end
        end
        tick();
        chk("busy_after_run", Busy, 0);
        chk("idx_after_run", BlockIdx, 0);
        chk("queue_drained", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        repeat (3) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_error", Error, 0);
        chk("rst_idx", BlockIdx, 0);
        chk("rst_enables", {CtEnable, LvlEnable, TzEnable, RbEnable}, 0);
        chk("rst_done", {BlockDone, RunDone}, 0);
        chk("rst_shift", ShiftEn, 0);
        nReset = 1;

        do_run(1);
        do_run(2);
        do_run(3);

        // Stalled level decoder: ERR exactly TO cycles after LvlEnable.
        tick(); Start = 1;
        expQ.push_back(EV_CT); expQ.push_back(EV_LVL); expQ.push_back(EV_ERR);
        wait_any(w, n); chk("to_ct", w, 1);
        pulse(1, 1, 3, 0);
        wait_any(w, n); chk("to_lvl", w, 2);
        n = 0;
        while (!Error && n < 20) begin tick(); n++; end
        chk("timeout_cycles", n, TO);
        recover(6);
        expQ.delete();

        // Shift priority in LEVEL and Abort beating Done/Start.
        tick(); Start = 1;
        expQ.push_back(EV_CT); expQ.push_back(EV_LVL);
        wait_any(w, n); chk("ab_ct", w, 1);
        pulse(1, 0, 5, 0);
        wait_any(w, n); chk("ab_lvl", w, 2);
        tick();
        CtShiftEn = 1; CtNumShift = 5'd3; LvlShiftEn = 1; LvlNumShift = 5'd7;
        #1;
        chk("lvl_shift_en", ShiftEn, 1);
        chk("lvl_num_shift", NumShift, 7);
        Abort = 1; LvlDone = 1; Start = 1; clrPh = 1;
        tick();
        chk("abort_busy_lvl", Busy, 0);
        chk("abort_shift_en", ShiftEn, 0);
        tick(); tick();
        chk("abort_stays_idle", Busy, 0);
        chk("abort_queue", expQ.size(), 0);
        expQ.delete();

        for (int i = 0; i < 20; i++) do_run(0);

        repeat (3) tick();
        chk("final_queue_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cavlc_block_ctrl.md
Name: cavlc_block_ctrl

Overview:
Parametrised successor to the CAVLC control FSM. Sequences all CAVLC syntax phases for one residual block: coeff_token, level, total_zeros and run_before. Loops over NUM_BLOCKS blocks per start, skips phases according to the decoded TotalCoeff/TotalZeros, and detects malformed streams and hung sub-decoders. Sits between the barrel shifter and the four sub-decoders, muxing their shift requests onto the single shifter port.

Parameters:
SHIFT_W, 5, width of NumShift buses
MAX_COEFF, 16, max coefficients per block (16, 15 or 4 for DC/AC/chroma-DC modes)
NUM_BLOCKS, 16, blocks decoded per Start
TIMEOUT, 255, max cycles in any phase waiting for Done before error (0 = disabled)

Ports:
Clk  in  1  clock
nReset  in  1  async active-low reset
Start  in  1  begin a run of NUM_BLOCKS blocks
Abort  in  1  synchronous abort, highest priority
BarrelShifterReady  in  1  shifter holds valid bits
CtDone/LvlDone/TzDone/RbDone  in  1 each  sub-decoder phase complete
CtShiftEn/LvlShiftEn/TzShiftEn/RbShiftEn  in  1 each  sub-decoder shift requests
CtNumShift/LvlNumShift/TzNumShift/RbNumShift  in  SHIFT_W each  shift amounts
TotalCoeff  in  5  from coeff_token decoder, valid with CtDone
TotalZeros  in  5  from total_zeros decoder, valid with TzDone
ShiftEn  out  1  to barrel shifter
NumShift  out  SHIFT_W  to barrel shifter
CtEnable/LvlEnable/TzEnable/RbEnable  out  1 each  phase start pulses
BlockIdx  out  clog2(NUM_BLOCKS)  index of current block
BlockDone  out  1  one-cycle pulse per completed block
RunDone  out  1  one-cycle pulse after last block
Busy  out  1  high in every state except IDLE and ERR
Error  out  1  sticky error flag

Behaviour:
- Reset: state IDLE. All outputs 0, BlockIdx 0, internal TotalCoeff/timeout registers 0.
- States: IDLE, WAIT_BS, COEFF, LEVEL, TZ, RUN, BLK_END, ERR.
- IDLE: Start moves to WAIT_BS and clears BlockIdx.
- WAIT_BS: moves to COEFF when BarrelShifterReady=1.
- COEFF: on CtDone, register TotalCoeff.
  - TotalCoeff > MAX_COEFF -> ERR.
  - TotalCoeff == 0 -> BLK_END.
  - Otherwise -> LEVEL.
- LEVEL: on LvlDone, TotalCoeff == MAX_COEFF -> BLK_END; else -> TZ.
- TZ: on TzDone.
  - TotalCoeff + TotalZeros > MAX_COEFF (6-bit sum) -> ERR.
  - TotalZeros == 0 -> BLK_END.
  - Otherwise -> RUN.
- RUN: on RbDone -> BLK_END.
- BLK_END: one cycle. BlockDone=1.
  - BlockIdx == NUM_BLOCKS-1: RunDone=1, BlockIdx <- 0, -> IDLE.
  - Else: BlockIdx+1, -> WAIT_BS.
- Enables: registered one-cycle pulse in the first cycle of each phase state (flop set when NextState enters the phase). Done is honoured in any cycle of the phase, including the first. Done received in any other state is ignored.
- Shift mux (combinational):
  - In a phase state, ShiftEn/NumShift mirror that phase's decoder.
  - In all other states, both are 0.
  - A ShiftEn coincident with Done is still forwarded.
  - Shift requests from inactive decoders are ignored.
- Timeout: counter clears on phase entry and increments each cycle in a phase without Done. Reaching TIMEOUT -> ERR. TIMEOUT = 0 disables the check.
- ERR: Error=1 and Busy=0. Start is ignored. Only Abort exits, to IDLE, clearing Error.
- Abort in any state: next state IDLE, BlockIdx 0, enables 0, Error 0. Abort beats a simultaneous Start or Done.
- Start while Busy is ignored.
- TotalCoeff==0 with MAX_COEFF=4 behaves identically (skip to BLK_END).

Decomposition:
- Shared package cavlc_pkg: state enum type, phase enum (CT, LVL, TZ, RB), MAX_COEFF defaults per mode constant.
- One natural sub-module: cavlc_shift_mux. Phase-select to ShiftEn/NumShift mux, reusable by the chroma controller.

Test Plan:
- NUM_BLOCKS=1, TotalCoeff=3, TotalZeros=2, each Done 2 cycles after its Enable -> CtEnable, LvlEnable, TzEnable, RbEnable in order; one BlockDone then RunDone the same cycle; Busy low after.
- TotalCoeff=0 -> BLK_END directly after COEFF, no LvlEnable; TotalCoeff=16 with MAX_COEFF=16 -> TzEnable never pulses.
- TotalCoeff=5, TotalZeros=12 -> ERR, Error=1, Start ignored; Abort -> IDLE, Error=0.
- TIMEOUT=8, LvlDone never asserted -> Error rises 8 cycles after LvlEnable.
- NUM_BLOCKS=4, BarrelShifterReady low 3 cycles before block 2 -> BlockIdx 0..3, 4 BlockDone pulses, COEFF entered only after Ready, RunDone once.
- LvlShiftEn=1, LvlNumShift=7 and CtShiftEn=1, CtNumShift=3 during LEVEL -> NumShift=7 forwarded; Abort mid-LEVEL -> next cycle IDLE, ShiftEn=0.
